// File: rtl/breakout_pkg.sv
// breakout_pkg: shared button constants and debounce channel state type
// Exports: BTN_IDX_* bit positions, N_BUTTONS, DEBOUNCE_CYCLES_DEFAULT, btn_state_e
package breakout_pkg;
    localparam int BTN_IDX_LEFT  = 0;
    localparam int BTN_IDX_RIGHT = 1;
    localparam int BTN_IDX_A     = 2;
    localparam int BTN_IDX_B     = 3;
    localparam int N_BUTTONS     = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 400000;
    typedef enum logic [1:0] {
        ST_UP,
        ST_SETTLE_DOWN,
        ST_DOWN,
        ST_SETTLE_UP
    } btn_state_e;
endpackage

// File: rtl/button_debounce_channel.sv
// button_debounce_channel: synchronize, debounce and edge-detect one button
// Ports: clk_i clock, rst_ni async active-low reset, btn_raw_i raw pad level,
//        frame_tick_i clears the latched press, level_o debounced level,
//        press_o one-cycle press pulse, latched_o sticky press flag
module button_debounce_channel
    import breakout_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_raw_i,
    input  logic frame_tick_i,
    output logic level_o,
    output logic press_o,
    output logic latched_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             latched_q, latched_d;
    logic             synced;

    assign synced = sync_q[1];

    // Counter defaults to zero so every exit from a settle state leaves it cleared
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            ST_UP:          state_d = synced ? ST_SETTLE_DOWN : ST_UP;
            ST_SETTLE_DOWN: begin
                if (!synced)            state_d = ST_UP;
                else if (cnt_q == LAST) state_d = ST_DOWN;
                else                    cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_DOWN:        state_d = synced ? ST_DOWN : ST_SETTLE_UP;
            ST_SETTLE_UP:   begin
                if (synced)             state_d = ST_DOWN;
                else if (cnt_q == LAST) state_d = ST_UP;
                else                    cnt_d   = cnt_q + CNT_W'(1);
            end
        endcase
        level_d   = (state_d == ST_DOWN) || (state_d == ST_SETTLE_UP);
        press_d   = level_d & ~level_q;
        // press_q keeps the flag set when a frame tick lands on the press pulse itself
        latched_d = press_d | press_q | (latched_q & ~frame_tick_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            state_q   <= ST_UP;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            latched_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_raw_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            latched_q <= latched_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign latched_o = latched_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: independent debounced button channels for the game inputs
// Ports: CLK system clock, RST_N async active-low reset (deassertion synchronized upstream),
//        BTN_RAW raw pad levels, FRAME_TICK frame-done strobe, BTN_LEVEL debounced levels,
//        BTN_PRESS press pulses, BTN_PRESS_LATCHED sticky press flags
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = breakout_pkg::DEBOUNCE_CYCLES_DEFAULT,
    parameter int          N_BUTTONS       = breakout_pkg::N_BUTTONS
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [N_BUTTONS-1:0] BTN_RAW,
    input  logic                 FRAME_TICK,
    output logic [N_BUTTONS-1:0] BTN_LEVEL,
    output logic [N_BUTTONS-1:0] BTN_PRESS,
    output logic [N_BUTTONS-1:0] BTN_PRESS_LATCHED
);
    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        button_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk_i       (CLK),
            .rst_ni      (RST_N),
            .btn_raw_i   (BTN_RAW[i]),
            .frame_tick_i(FRAME_TICK),
            .level_o     (BTN_LEVEL[i]),
            .press_o     (BTN_PRESS[i]),
            .latched_o   (BTN_PRESS_LATCHED[i])
        );
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: random and directed stimulus against a sliding-window reference model
module tb_button_conditioner;
    localparam int D = 8;
    localparam int N = 4;
    localparam int H = D + 3;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [N-1:0] BTN_RAW = '0;
    logic         FRAME_TICK = 1'b0;
    logic [N-1:0] BTN_LEVEL, BTN_PRESS, BTN_PRESS_LATCHED;

    int n_checks = 0;
    int n_fail = 0;

    logic [N-1:0] m_hist [H];
    logic [N-1:0] m_level, m_press, m_latched;

    button_conditioner #(.DEBOUNCE_CYCLES(D), .N_BUTTONS(N)) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .BTN_RAW          (BTN_RAW),
        .FRAME_TICK       (FRAME_TICK),
        .BTN_LEVEL        (BTN_LEVEL),
        .BTN_PRESS        (BTN_PRESS),
        .BTN_PRESS_LATCHED(BTN_PRESS_LATCHED)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < H; k++) m_hist[k] = '0;
        m_level = '0;
        m_press = '0;
        m_latched = '0;
    endtask

    // A level flips once the last D+1 synchronized samples all disagree with it;
    // synchronized samples are raw samples two edges old.
    task automatic model_edge();
        logic [N-1:0] nlev, npress;
        if (!RST_N) begin
            model_reset();
            return;
        end
        for (int k = H - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = BTN_RAW;
        nlev = m_level;
        for (int c = 0; c < N; c++) begin
            bit stable = 1'b1;
            for (int k = 2; k < H; k++) if (m_hist[k][c] != m_hist[2][c]) stable = 1'b0;
            if (stable) nlev[c] = m_hist[2][c];
        end
        npress = nlev & ~m_level;
        m_latched = npress | m_press | (m_latched & ~{N{FRAME_TICK}});
        m_press = npress;
        m_level = nlev;
    endtask

    task automatic check_outputs(input string ctx);
        check({ctx, "_level"}, int'(BTN_LEVEL), int'(m_level));
        check({ctx, "_press"}, int'(BTN_PRESS), int'(m_press));
        check({ctx, "_latched"}, int'(BTN_PRESS_LATCHED), int'(m_latched));
    endtask

    task automatic step(input string ctx);
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs(ctx);
    endtask

    task automatic assert_reset();
        RST_N = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
    endtask

    int k;
    int presses;
    int hold [N];

    initial begin
        model_reset();
        // reset and idle
        step("rst");
        step("rst");
        RST_N = 1'b1;
        for (int i = 0; i < 20; i++) step("idle");

        // single press on LEFT: latency, one pulse, sticky until frame tick
        BTN_RAW[0] = 1'b1;
        step("press0");
        k = 0;
        do begin
            step("press0");
            k++;
        end while (!BTN_LEVEL[0] && k < 40);
        check("press0_latency", k, D + 2);
        check("press0_pulse", int'(BTN_PRESS[0]), 1);
        for (int i = 0; i < 5; i++) step("hold0");
        check("latched0_held", int'(BTN_PRESS_LATCHED[0]), 1);
        FRAME_TICK = 1'b1;
        step("tick0");
        FRAME_TICK = 1'b0;
        check("latched0_cleared", int'(BTN_PRESS_LATCHED[0]), 0);
        step("after_tick0");

        // glitches on A never get through
        for (int i = 0; i < 100; i++) begin
            BTN_RAW[2] = (i % 5 == 0);
            step("glitch2");
            if (BTN_LEVEL[2] || BTN_PRESS[2]) check("glitch2_quiet", 1, 0);
        end
        BTN_RAW[2] = 1'b0;

        // frame tick on the press pulse: set wins, next tick clears
        BTN_RAW[1] = 1'b1;
        k = 0;
        do begin
            step("press1");
            k++;
        end while (!BTN_PRESS[1] && k < 40);
        check("press1_seen", int'(BTN_PRESS[1]), 1);
        FRAME_TICK = 1'b1;
        step("tick1_coincide");
        FRAME_TICK = 1'b0;
        check("latched1_kept", int'(BTN_PRESS_LATCHED[1]), 1);
        step("gap1");
        FRAME_TICK = 1'b1;
        step("tick1_clear");
        FRAME_TICK = 1'b0;
        check("latched1_cleared", int'(BTN_PRESS_LATCHED[1]), 0);

        // release everything, then all four held with reset mid-settle
        BTN_RAW = '0;
        for (int i = 0; i < 20; i++) step("release");
        BTN_RAW = '1;
        for (int i = 0; i < 5; i++) step("settle_all");
        assert_reset();
        step("rst_hold");
        step("rst_hold");
        RST_N = 1'b1;
        k = 0;
        do begin
            step("repress_all");
            k++;
        end while (BTN_PRESS == '0 && k < 40);
        check("rst_repress_latency", k - 1, D + 2);
        check("rst_repress_all", int'(BTN_PRESS), 'hF);
        for (int i = 0; i < 5; i++) step("hold_all");

        // short release on B keeps it down with no second pulse
        BTN_RAW = 4'b1000;
        for (int i = 0; i < 15; i++) step("b_only");
        presses = 0;
        BTN_RAW[3] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("b_gap");
            presses += int'(BTN_PRESS[3]);
        end
        BTN_RAW[3] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step("b_repress");
            presses += int'(BTN_PRESS[3]);
        end
        check("b_level_held", int'(BTN_LEVEL[3]), 1);
        check("b_no_second_pulse", presses, 0);

        // random bouncing, frame ticks and occasional reset
        for (int c = 0; c < N; c++) hold[c] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    BTN_RAW[c] = 1'($urandom_range(0, 1));
                    hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(D + 2, 3 * D))
                                                           : int'($urandom_range(1, D + 1));
                end
                hold[c]--;
            end
            FRAME_TICK = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 599) == 0) begin
                assert_reset();
                step("rand_rst");
                RST_N = 1'b1;
            end
            step("rand");
        end
        FRAME_TICK = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
